// File: rtl/bank_cmd_scheduler.sv
// DRAM command scheduler: turns one granted request at a time into ACT/PRE/RD/WR/PREA
// commands, tracking 16 open rows and spacing commands by tRP, tRCD and tCCD.
module bank_cmd_scheduler #(
    parameter int IDX   = 6,
    parameter int RA    = 16,
    parameter int CA    = 10,
    parameter int T_RCD = 4,
    parameter int T_RP  = 4,
    parameter int T_CCD = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [RA-1:0]  req_row,
    input  logic [CA-1:0]  req_col,
    input  logic [1:0]     req_ba,
    input  logic [1:0]     req_bg,
    input  logic           req_t,
    input  logic [IDX-1:0] req_idx,
    input  logic           pa_req,
    output logic           pa_ack,
    output logic           cmd_valid,
    output logic [2:0]     cmd,
    output logic [1:0]     cmd_bg,
    output logic [1:0]     cmd_ba,
    output logic [RA-1:0]  cmd_addr,
    output logic [IDX-1:0] cmd_idx
);

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_WR   = 3'd3;
    localparam logic [2:0] CMD_PRE  = 3'd4;
    localparam logic [2:0] CMD_PREA = 3'd5;

    localparam int T_MAX = (T_RP > T_RCD) ? ((T_RP > T_CCD) ? T_RP : T_CCD)
                                          : ((T_RCD > T_CCD) ? T_RCD : T_CCD);
    localparam int CW = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    // Wait states cover the cycles strictly between a command and its successor.
    localparam logic [CW-1:0] RP_LOAD  = CW'((T_RP > 2) ? T_RP - 2 : 0);
    localparam logic [CW-1:0] RCD_LOAD = CW'((T_RCD > 2) ? T_RCD - 2 : 0);
    localparam logic [CW-1:0] CCD_LOAD = CW'(T_CCD - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_PREA, S_ACT, S_WAIT_RP, S_WAIT_RCD, S_COL
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   rp_cnt_r, rp_cnt_s;
    logic [CW-1:0]   rcd_cnt_r, rcd_cnt_s;
    logic [CW-1:0]   ccd_cnt_r, ccd_cnt_s;
    logic            prea_r, prea_s;
    logic            accept_s;
    logic [3:0]      req_bank_s;
    logic [3:0]      bank_r, bank_s;
    logic [RA-1:0]   row_r, row_s;
    logic [CA-1:0]   col_r, col_s;
    logic            t_r, t_s;
    logic [IDX-1:0]  idx_r, idx_s;
    logic [15:0]     open_r;
    logic [RA-1:0]   row_tab_r [16];

    logic            cmd_valid_s;
    logic [2:0]      cmd_s;
    logic [1:0]      cmd_bg_s;
    logic [1:0]      cmd_ba_s;
    logic [RA-1:0]   cmd_addr_s;
    logic [IDX-1:0]  cmd_idx_s;
    logic            pa_ack_s;

    assign req_bank_s = {req_bg, req_ba};
    assign req_ready  = (state_r == S_IDLE) && !pa_req;

    // Next-state, timer and held-request logic.
    always_comb begin
        state_s   = state_r;
        rp_cnt_s  = rp_cnt_r;
        rcd_cnt_s = rcd_cnt_r;
        prea_s    = prea_r;
        ccd_cnt_s = (ccd_cnt_r != '0) ? (ccd_cnt_r - CNT_ONE) : ccd_cnt_r;
        accept_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (pa_req) begin
                    state_s = S_PREA;
                end else if (req_valid) begin
                    accept_s = 1'b1;
                    if (!open_r[req_bank_s]) begin
                        state_s = S_ACT;
                    end else if (row_tab_r[req_bank_s] == req_row) begin
                        state_s = S_COL;
                    end else begin
                        state_s = S_PRE;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PRE: begin
                prea_s   = 1'b0;
                rp_cnt_s = RP_LOAD;
                if (T_RP <= 1) begin
                    state_s = S_ACT;
                end else begin
                    state_s = S_WAIT_RP;
                end
            end
            S_PREA: begin
                prea_s   = 1'b1;
                rp_cnt_s = RP_LOAD;
                // After PREA the next ACT can follow the IDLE handshake, so IDLE is reached one cycle early.
                if (T_RP <= 2) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_WAIT_RP;
                end
            end
            S_WAIT_RP: begin
                if (prea_r ? (rp_cnt_r <= CNT_ONE) : (rp_cnt_r == '0)) begin
                    state_s = prea_r ? S_IDLE : S_ACT;
                end else begin
                    rp_cnt_s = rp_cnt_r - CNT_ONE;
                end
            end
            S_ACT: begin
                rcd_cnt_s = RCD_LOAD;
                if (T_RCD <= 1) begin
                    state_s = S_COL;
                end else begin
                    state_s = S_WAIT_RCD;
                end
            end
            S_WAIT_RCD: begin
                if (rcd_cnt_r == '0) begin
                    state_s = S_COL;
                end else begin
                    rcd_cnt_s = rcd_cnt_r - CNT_ONE;
                end
            end
            S_COL: begin
                if (ccd_cnt_r == '0) begin
                    state_s   = S_IDLE;
                    ccd_cnt_s = CCD_LOAD;
                end else begin
                    state_s = S_COL;
                end
            end
            default: state_s = S_IDLE;
        endcase

        if (accept_s) begin
            bank_s = req_bank_s;
            row_s  = req_row;
            col_s  = req_col;
            t_s    = req_t;
            idx_s  = req_idx;
        end else begin
            bank_s = bank_r;
            row_s  = row_r;
            col_s  = col_r;
            t_s    = t_r;
            idx_s  = idx_r;
        end
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        cmd_valid_s = 1'b0;
        cmd_s       = CMD_NOP;
        cmd_bg_s    = 2'd0;
        cmd_ba_s    = 2'd0;
        cmd_addr_s  = '0;
        cmd_idx_s   = '0;
        pa_ack_s    = 1'b0;
        case (state_s)
            S_ACT: begin
                cmd_valid_s = 1'b1;
                cmd_s       = CMD_ACT;
                cmd_bg_s    = bank_s[3:2];
                cmd_ba_s    = bank_s[1:0];
                cmd_addr_s  = row_s;
            end
            S_PRE: begin
                cmd_valid_s = 1'b1;
                cmd_s       = CMD_PRE;
                cmd_bg_s    = bank_s[3:2];
                cmd_ba_s    = bank_s[1:0];
            end
            S_PREA: begin
                cmd_valid_s = 1'b1;
                cmd_s       = CMD_PREA;
                pa_ack_s    = 1'b1;
            end
            S_COL: begin
                if (ccd_cnt_s == '0) begin
                    cmd_valid_s          = 1'b1;
                    cmd_s                = t_s ? CMD_WR : CMD_RD;
                    cmd_bg_s             = bank_s[3:2];
                    cmd_ba_s             = bank_s[1:0];
                    cmd_addr_s[CA-1:0]   = col_s;
                    cmd_idx_s            = idx_s;
                end else begin
                    cmd_valid_s = 1'b0;
                end
            end
            default: cmd_valid_s = 1'b0;
        endcase
    end

    // Control state, timers, held request and open-row table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            rp_cnt_r  <= '0;
            rcd_cnt_r <= '0;
            ccd_cnt_r <= '0;
            prea_r    <= 1'b0;
            bank_r    <= 4'd0;
            row_r     <= '0;
            col_r     <= '0;
            t_r       <= 1'b0;
            idx_r     <= '0;
            open_r    <= 16'd0;
            for (int i = 0; i < 16; i++) begin
                row_tab_r[i] <= '0;
            end
        end else begin
            state_r   <= state_s;
            rp_cnt_r  <= rp_cnt_s;
            rcd_cnt_r <= rcd_cnt_s;
            ccd_cnt_r <= ccd_cnt_s;
            prea_r    <= prea_s;
            bank_r    <= bank_s;
            row_r     <= row_s;
            col_r     <= col_s;
            t_r       <= t_s;
            idx_r     <= idx_s;
            if (state_r == S_ACT) begin
                open_r[bank_r]    <= 1'b1;
                row_tab_r[bank_r] <= row_r;
            end else if (state_r == S_PRE) begin
                open_r[bank_r] <= 1'b0;
            end else if (state_r == S_PREA) begin
                open_r <= 16'd0;
            end
        end
    end

    // Registered command bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd       <= CMD_NOP;
            cmd_bg    <= 2'd0;
            cmd_ba    <= 2'd0;
            cmd_addr  <= '0;
            cmd_idx   <= '0;
            pa_ack    <= 1'b0;
        end else begin
            cmd_valid <= cmd_valid_s;
            cmd       <= cmd_s;
            cmd_bg    <= cmd_bg_s;
            cmd_ba    <= cmd_ba_s;
            cmd_addr  <= cmd_addr_s;
            cmd_idx   <= cmd_idx_s;
            pa_ack    <= pa_ack_s;
        end
    end

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Bench for bank_cmd_scheduler: directed vector table with fixed latencies, a reset
// corner sequence, then random traffic against a cycle-scheduled reference model.
module tb_bank_cmd_scheduler;

    localparam int IDX   = 6;
    localparam int RA    = 16;
    localparam int CA    = 10;
    localparam int T_RCD = 4;
    localparam int T_RP  = 3;
    localparam int T_CCD = 2;
    localparam int K_HIT = 0, K_CLOSED = 1, K_CONFLICT = 2, K_PREA = 3;
    // Cycles from PREA until the scheduler is back in IDLE.
    localparam int PREA_IDLE = (T_RP > 1) ? T_RP - 1 : 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [RA-1:0]  req_row = '0;
    logic [CA-1:0]  req_col = '0;
    logic [1:0]     req_ba = 2'd0;
    logic [1:0]     req_bg = 2'd0;
    logic           req_t = 1'b0;
    logic [IDX-1:0] req_idx = '0;
    logic           pa_req = 1'b0;
    logic           pa_ack;
    logic           cmd_valid;
    logic [2:0]     cmd;
    logic [1:0]     cmd_bg;
    logic [1:0]     cmd_ba;
    logic [RA-1:0]  cmd_addr;
    logic [IDX-1:0] cmd_idx;

    bank_cmd_scheduler #(
        .IDX(IDX), .RA(RA), .CA(CA), .T_RCD(T_RCD), .T_RP(T_RP), .T_CCD(T_CCD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_row(req_row), .req_col(req_col), .req_ba(req_ba), .req_bg(req_bg),
        .req_t(req_t), .req_idx(req_idx),
        .pa_req(pa_req), .pa_ack(pa_ack),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba),
        .cmd_addr(cmd_addr), .cmd_idx(cmd_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic           v;
        logic [2:0]     cmd;
        logic [1:0]     bg;
        logic [1:0]     ba;
        logic [RA-1:0]  addr;
        logic [IDX-1:0] idx;
    } exp_t;

    typedef struct {
        logic           pa;
        logic [1:0]     bg;
        logic [1:0]     ba;
        logic [RA-1:0]  row;
        logic [CA-1:0]  col;
        logic           t;
        logic [IDX-1:0] idx;
        int             kind;
        int             lat;
    } vec_t;

    int n_checks = 0;
    int n_fail = 0;
    int last_col = 0;
    int prev_col = 0;
    vec_t vecs [10];

    // Reference model state for the random phase.
    bit             open_m [16];
    logic [RA-1:0]  row_m [16];
    exp_t           expq [64];
    int             rdy_cyc;
    int             last_col_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [2:0] c, input logic [1:0] bg, input logic [1:0] ba,
                                    input logic [RA-1:0] addr, input logic [IDX-1:0] idx);
        exp_t e;
        e.v = 1'b1; e.cmd = c; e.bg = bg; e.ba = ba; e.addr = addr; e.idx = idx;
        return e;
    endfunction

    function automatic logic [31:0] pack_exp(input exp_t e);
        if (e.v) return {1'b0, 1'b1, e.cmd, e.bg, e.ba, e.addr, e.idx, (e.cmd == 3'd5)};
        return 32'd0;
    endfunction

    function automatic logic [31:0] dut_pack();
        return {1'b0, cmd_valid, cmd, cmd_bg, cmd_ba, cmd_addr, cmd_idx, pa_ack};
    endfunction

    // Expected bus contents o cycles after the handshake of directed vector v.
    function automatic exp_t exp_vec(input vec_t v, input int o);
        exp_t e;
        e = '{default: '0};
        if (v.kind == K_PREA) begin
            if (o == 1) e = mk_exp(3'd5, 2'd0, 2'd0, 16'd0, 6'd0);
        end else begin
            if (o == 1 && v.kind == K_CLOSED) e = mk_exp(3'd1, v.bg, v.ba, v.row, 6'd0);
            if (o == 1 && v.kind == K_CONFLICT) e = mk_exp(3'd4, v.bg, v.ba, 16'd0, 6'd0);
            if (o == 1 + T_RP && v.kind == K_CONFLICT) e = mk_exp(3'd1, v.bg, v.ba, v.row, 6'd0);
            if (o == v.lat) e = mk_exp(v.t ? 3'd3 : 3'd2, v.bg, v.ba, RA'(v.col), v.idx);
        end
        return e;
    endfunction

    // Called at a negedge in a cycle where the scheduler is expected to be ready.
    task automatic run_vec(input vec_t v, input string name);
        int rdy_off;
        req_valid = 1'b1; pa_req = v.pa;
        req_bg = v.bg; req_ba = v.ba; req_row = v.row; req_col = v.col;
        req_t = v.t; req_idx = v.idx;
        #1;
        chk({name, " ready_at_req"}, 32'(req_ready), 32'(!v.pa));
        rdy_off = (v.kind == K_PREA) ? 1 + PREA_IDLE : v.lat + 1;
        for (int o = 1; o <= rdy_off; o++) begin
            @(posedge clk); #1;
            req_valid = 1'b0; pa_req = 1'b0;
            @(negedge clk);
            chk($sformatf("%s cmd+%0d", name, o), dut_pack(), pack_exp(exp_vec(v, o)));
            chk($sformatf("%s ready+%0d", name, o), 32'(req_ready), 32'(o == rdy_off));
            if (o == v.lat && v.kind != K_PREA) begin
                prev_col = last_col;
                last_col = cyc;
            end
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 2'd1, 2'd2, 16'h0ABC, 10'h015, 1'b0, 6'd5,  K_CLOSED,   5};
        vecs[1] = '{1'b0, 2'd1, 2'd2, 16'h0ABC, 10'h016, 1'b1, 6'd9,  K_HIT,      1};
        vecs[2] = '{1'b0, 2'd1, 2'd2, 16'h1234, 10'h020, 1'b0, 6'd3,  K_CONFLICT, 8};
        vecs[3] = '{1'b1, 2'd1, 2'd2, 16'h1234, 10'h021, 1'b1, 6'd11, K_PREA,     0};
        vecs[4] = '{1'b0, 2'd1, 2'd2, 16'h1234, 10'h021, 1'b1, 6'd11, K_CLOSED,   5};
        vecs[5] = '{1'b0, 2'd0, 2'd0, 16'h0100, 10'h001, 1'b0, 6'd1,  K_CLOSED,   5};
        vecs[6] = '{1'b0, 2'd1, 2'd1, 16'h0500, 10'h002, 1'b0, 6'd2,  K_CLOSED,   5};
        vecs[7] = '{1'b0, 2'd0, 2'd0, 16'h0100, 10'h003, 1'b1, 6'd4,  K_HIT,      1};
        vecs[8] = '{1'b0, 2'd1, 2'd1, 16'h0500, 10'h004, 1'b0, 6'd6,  K_HIT,      1};
        vecs[9] = '{1'b0, 2'd0, 2'd0, 16'h0200, 10'h005, 1'b0, 6'd7,  K_CONFLICT, 8};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset outputs", dut_pack(), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready after reset", 32'(req_ready), 32'd1);

        // Directed vectors, each handshake in the cycle the previous one frees the scheduler.
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 8) chk("ccd gap b0->b5", 32'(last_col - prev_col), 32'd2);
        end

        // Reset while waiting for tRCD abandons the request and clears the table.
        req_valid = 1'b1; req_bg = 2'd0; req_ba = 2'd3; req_row = 16'h0777;
        req_col = 10'h007; req_t = 1'b0; req_idx = 6'd13;
        #1;
        chk("rst seq ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst seq act", dut_pack(), pack_exp(mk_exp(3'd1, 2'd0, 2'd3, 16'h0777, 6'd0)));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst seq outputs", dut_pack(), 32'd0);
        for (int i = 0; i < T_RCD + 4; i++) begin
            @(negedge clk);
            chk($sformatf("rst seq no cmd %0d", i), dut_pack(), 32'd0);
            if (i == 1) rst_n = 1'b1;
        end
        run_vec('{1'b0, 2'd0, 2'd3, 16'h0777, 10'h007, 1'b0, 6'd13, K_CLOSED, 5}, "after reset");

        // Random traffic against the reference model, starting from a fresh reset.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            open_m[i] = 1'b0;
            row_m[i] = '0;
        end
        for (int i = 0; i < 64; i++) expq[i] = '{default: '0};
        rdy_cyc = 0;
        last_col_m = -100;
        for (int k = 0; k < 3000; k++) begin
            bit idle;
            int b;
            int colc;
            @(posedge clk); #1;
            idle = (k >= rdy_cyc);
            req_valid = 1'b0;
            pa_req = 1'b0;
            if (idle && $urandom_range(0, 15) == 0) begin
                pa_req = 1'b1;
            end else if ($urandom_range(0, 3) != 0) begin
                req_valid = 1'b1;
                req_bg  = 2'($urandom_range(0, 3));
                req_ba  = 2'($urandom_range(0, 1));
                req_row = 16'($urandom_range(0, 2)) * 16'h1111;
                req_col = 10'($urandom_range(0, 1023));
                req_t   = 1'($urandom_range(0, 1));
                req_idx = 6'($urandom_range(0, 63));
            end
            @(negedge clk);
            chk("rand cmd", dut_pack(), pack_exp(expq[k % 64]));
            expq[k % 64] = '{default: '0};
            chk("rand ready", 32'(req_ready), 32'(idle && !pa_req));
            if (idle && pa_req) begin
                expq[(k + 1) % 64] = mk_exp(3'd5, 2'd0, 2'd0, 16'd0, 6'd0);
                for (int i = 0; i < 16; i++) open_m[i] = 1'b0;
                rdy_cyc = k + 1 + PREA_IDLE;
            end else if (idle && req_valid) begin
                b = int'({req_bg, req_ba});
                if (open_m[b] && row_m[b] == req_row) begin
                    colc = k + 1;
                end else if (!open_m[b]) begin
                    expq[(k + 1) % 64] = mk_exp(3'd1, req_bg, req_ba, req_row, 6'd0);
                    colc = k + 1 + T_RCD;
                end else begin
                    expq[(k + 1) % 64] = mk_exp(3'd4, req_bg, req_ba, 16'd0, 6'd0);
                    expq[(k + 1 + T_RP) % 64] = mk_exp(3'd1, req_bg, req_ba, req_row, 6'd0);
                    colc = k + 1 + T_RP + T_RCD;
                end
                if (colc < last_col_m + T_CCD) colc = last_col_m + T_CCD;
                expq[colc % 64] = mk_exp(req_t ? 3'd3 : 3'd2, req_bg, req_ba, RA'(req_col), req_idx);
                open_m[b] = 1'b1;
                row_m[b] = req_row;
                last_col_m = colc;
                rdy_cyc = colc + 1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
